// File: rtl/vga_paddle_engine.sv
// N-player paddle engine: synchronised buttons, tick-divided clamped paddle motion under an
// IDLE/RUN/PAUSE FSM, and a registered per-pixel paddle coverage lookup.
module vga_paddle_engine #(
    parameter int N_PAD    = 2,
    parameter int COORD_W  = 10,
    parameter int TICK_W   = 21,
    parameter int STEP     = 2,
    parameter int PAD_HALF = 10,
    parameter int PAD_W    = 32,
    parameter int PAD_X0   = 224,
    parameter int PAD_DX   = 192,
    parameter int Y_MIN    = 6,
    parameter int Y_MAX    = 468,
    parameter int Y_INIT   = 240
) (
    input  logic                       board_clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear,
    input  logic [N_PAD-1:0]           btn_up,
    input  logic [N_PAD-1:0]           btn_dn,
    input  logic                       pix_ce,
    input  logic [COORD_W-1:0]         counter_x,
    input  logic [COORD_W-1:0]         counter_y,
    input  logic                       in_display,
    output logic [N_PAD*COORD_W-1:0]   pad_pos,
    output logic                       pixel_on,
    output logic [1:0]                 pixel_id,
    output logic [1:0]                 state,
    output logic                       tick
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // One spare bit keeps pos-STEP and pos-PAD_HALF from wrapping below zero.
    localparam logic signed [COORD_W:0] LIM_LO = (COORD_W+1)'(Y_MIN + PAD_HALF);
    localparam logic signed [COORD_W:0] LIM_HI = (COORD_W+1)'(Y_MAX - PAD_HALF);
    localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(STEP);
    localparam logic signed [COORD_W:0] HALF_S = (COORD_W+1)'(PAD_HALF);
    localparam logic [COORD_W-1:0]      Y_INIT_V = COORD_W'(Y_INIT);

    logic [1:0]       start_sync;
    logic [1:0]       clear_sync;
    logic [N_PAD-1:0] up_meta, up_s;
    logic [N_PAD-1:0] dn_meta, dn_s;
    logic             start_s;
    logic             clear_s;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            clear_sync <= '0;
            up_meta    <= '0;
            up_s       <= '0;
            dn_meta    <= '0;
            dn_s       <= '0;
        end else begin
            start_sync <= {start_sync[0], start};
            clear_sync <= {clear_sync[0], clear};
            up_meta    <= btn_up;
            up_s       <= up_meta;
            dn_meta    <= btn_dn;
            dn_s       <= dn_meta;
        end
    end

    assign start_s = start_sync[1];
    assign clear_s = clear_sync[1];

    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = &tick_cnt;

    state_t state_q, state_d;
    logic   move_en;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        move_en = 1'b0;
        if (clear_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_s)  state_d = S_RUN;
                S_RUN:   if (!start_s) state_d = S_PAUSE;
                S_PAUSE: if (start_s)  state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
        // A tick on the cycle the FSM drops out of RUN does not move anything.
        move_en = (state_q == S_RUN) && (state_d == S_RUN) && tick;
    end

    assign state = state_q;

    logic [N_PAD-1:0] hit;

    for (genvar i = 0; i < N_PAD; i++) begin : g_pad
        localparam int X_LO = PAD_X0 + i * PAD_DX;
        localparam int X_HI = X_LO + PAD_W - 1;

        logic [COORD_W-1:0]        pos_r;
        logic [COORD_W-1:0]        pos_nxt;
        logic signed [COORD_W:0]   pos_s;
        logic signed [COORD_W:0]   dec_s;
        logic signed [COORD_W:0]   inc_s;
        logic signed [COORD_W:0]   top_s;
        logic signed [COORD_W:0]   bot_s;
        logic signed [COORD_W:0]   y_s;
        logic [31:0]               x_u;
        logic                      x_ok;
        logic                      y_ok;

        assign pos_s = signed'({1'b0, pos_r});
        assign dec_s = pos_s - STEP_S;
        assign inc_s = pos_s + STEP_S;

        always_comb begin
            pos_nxt = pos_r;
            if (clear_s) begin
                pos_nxt = Y_INIT_V;
            end else if (move_en) begin
                if (up_s[i] && !dn_s[i]) begin
                    pos_nxt = (dec_s < LIM_LO) ? LIM_LO[COORD_W-1:0] : dec_s[COORD_W-1:0];
                end else if (dn_s[i] && !up_s[i]) begin
                    pos_nxt = (inc_s > LIM_HI) ? LIM_HI[COORD_W-1:0] : inc_s[COORD_W-1:0];
                end
            end
        end

        always_ff @(posedge board_clk or posedge reset) begin
            if (reset) begin
                pos_r <= Y_INIT_V;
            end else begin
                pos_r <= pos_nxt;
            end
        end

        assign pad_pos[i*COORD_W +: COORD_W] = pos_r;

        assign top_s = pos_s - HALF_S;
        assign bot_s = pos_s + HALF_S;
        assign y_s   = signed'({1'b0, counter_y});
        assign x_u   = 32'(counter_x);
        assign x_ok  = (x_u >= 32'(X_LO)) && (x_u <= 32'(X_HI));
        assign y_ok  = (y_s >= top_s) && (y_s <= bot_s);
        assign hit[i] = x_ok && y_ok;
    end

    logic [1:0] hit_id;

    always_comb begin
        hit_id = 2'd0;
        for (int i = N_PAD - 1; i >= 0; i--) begin
            if (hit[i]) hit_id = 2'(i);
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            pixel_on <= 1'b0;
            pixel_id <= 2'd0;
        end else if (pix_ce) begin
            pixel_on <= in_display && (|hit);
            pixel_id <= hit_id;
        end
    end

endmodule

// File: tb/tb_vga_paddle_engine.sv
// Directed bench for vga_paddle_engine with a 16-cycle movement tick (TICK_W=4).
module tb_vga_paddle_engine;

    localparam int N_PAD   = 2;
    localparam int COORD_W = 10;
    localparam int TICK_W  = 4;

    logic                     board_clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     clear;
    logic [N_PAD-1:0]         btn_up;
    logic [N_PAD-1:0]         btn_dn;
    logic                     pix_ce;
    logic [COORD_W-1:0]       counter_x;
    logic [COORD_W-1:0]       counter_y;
    logic                     in_display;
    logic [N_PAD*COORD_W-1:0] pad_pos;
    logic                     pixel_on;
    logic [1:0]               pixel_id;
    logic [1:0]               state;
    logic                     tick;

    int n_checks = 0;
    int n_pass   = 0;

    vga_paddle_engine #(
        .N_PAD   (N_PAD),
        .COORD_W (COORD_W),
        .TICK_W  (TICK_W)
    ) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .pix_ce     (pix_ce),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .in_display (in_display),
        .pad_pos    (pad_pos),
        .pixel_on   (pixel_on),
        .pixel_id   (pixel_id),
        .state      (state),
        .tick       (tick)
    );

    always #5 board_clk = ~board_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] pos(input int i);
        return 32'(pad_pos[i*COORD_W +: COORD_W]);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    // Returns one cycle after the n-th tick, so the resulting move is already visible.
    task automatic wait_ticks(input int n);
        bit found;
        for (int k = 0; k < n; k++) begin
            found = 1'b0;
            for (int c = 0; c < 64; c++) begin
                @(negedge board_clk);
                if (tick) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                check("tick_timeout", 32'd0, 32'd1);
                return;
            end
        end
        @(negedge board_clk);
    endtask

    task automatic render(input string tag, input int x, input int y, input logic disp,
                          input logic exp_on, input logic [1:0] exp_id);
        counter_x  = COORD_W'(x);
        counter_y  = COORD_W'(y);
        in_display = disp;
        pix_ce     = 1'b1;
        @(negedge board_clk);
        pix_ce = 1'b0;
        check({tag, "_on"}, 32'(pixel_on), 32'(exp_on));
        check({tag, "_id"}, 32'(pixel_id), 32'(exp_id));
    endtask

    initial begin
        int gap;
        reset      = 1'b1;
        start      = 1'b0;
        clear      = 1'b0;
        btn_up     = '0;
        btn_dn     = '0;
        pix_ce     = 1'b0;
        counter_x  = '0;
        counter_y  = '0;
        in_display = 1'b0;
        cycles(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pos0", pos(0), 32'd240);
        check("rst_pos1", pos(1), 32'd240);
        check("rst_pixel_on", 32'(pixel_on), 32'd0);
        check("rst_pixel_id", 32'(pixel_id), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;

        // IDLE ignores buttons
        btn_up = 2'b01;
        wait_ticks(4);
        check("idle_state", 32'(state), 32'd0);
        check("idle_pos0", pos(0), 32'd240);
        btn_up = 2'b00;
        cycles(4);

        // RUN, tick shape, paddle 1 down
        start = 1'b1;
        cycles(4);
        check("run_state", 32'(state), 32'd1);
        wait_ticks(1);
        check("tick_width", 32'(tick), 32'd0);
        gap = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge board_clk);
            gap++;
            if (tick) break;
        end
        check("tick_period", 32'(gap), 32'd15);
        @(negedge board_clk);
        btn_dn = 2'b10;
        wait_ticks(5);
        check("dn5_pos1", pos(1), 32'd250);
        check("dn5_pos0", pos(0), 32'd240);
        check("dn5_state", 32'(state), 32'd1);

        // top clamp
        btn_dn = 2'b00;
        btn_up = 2'b01;
        wait_ticks(50);
        check("up50_pos0", pos(0), 32'd140);
        wait_ticks(150);
        check("up200_pos0", pos(0), 32'd16);
        check("up200_pos1", pos(1), 32'd250);
        render("top_edge", 224, 6, 1'b1, 1'b1, 2'd0);
        render("above_top", 224, 5, 1'b1, 1'b0, 2'd0);
        render("bot_edge", 224, 26, 1'b1, 1'b1, 2'd0);
        render("below_bot", 224, 27, 1'b1, 1'b0, 2'd0);

        // bottom clamp
        btn_up = 2'b00;
        btn_dn = 2'b01;
        wait_ticks(250);
        check("dn250_pos0", pos(0), 32'd458);

        // both pressed holds
        btn_dn = 2'b00;
        btn_up = 2'b01;
        wait_ticks(4);
        check("up4_pos0", pos(0), 32'd450);
        btn_dn = 2'b01;
        wait_ticks(3);
        check("both_pos0", pos(0), 32'd450);

        // PAUSE freezes, RUN resumes
        start  = 1'b0;
        btn_dn = 2'b00;
        cycles(4);
        check("pause_state", 32'(state), 32'd2);
        wait_ticks(3);
        check("pause_pos0", pos(0), 32'd450);
        start = 1'b1;
        cycles(4);
        check("resume_state", 32'(state), 32'd1);
        wait_ticks(1);
        check("resume_pos0", pos(0), 32'd448);

        // clear through the synchroniser
        btn_up = 2'b00;
        cycles(4);
        clear = 1'b1;
        @(negedge board_clk);
        clear = 1'b0;
        cycles(1);
        check("clear_early_pos0", pos(0), 32'd448);
        cycles(1);
        check("clear_state", 32'(state), 32'd0);
        check("clear_pos0", pos(0), 32'd240);
        check("clear_pos1", pos(1), 32'd240);
        start = 1'b0;
        cycles(4);
        check("idle_run_pause", 32'(state), 32'd2);

        // render at centred paddles
        render("p0_corner", 224, 230, 1'b1, 1'b1, 2'd0);
        render("p0_y229", 224, 229, 1'b1, 1'b0, 2'd0);
        render("p0_x256", 256, 240, 1'b1, 1'b0, 2'd0);
        render("no_disp", 224, 240, 1'b0, 1'b0, 2'd0);
        render("p0_far", 255, 250, 1'b1, 1'b1, 2'd0);
        render("p1_hit", 416, 240, 1'b1, 1'b1, 2'd1);
        counter_x = '0;
        @(negedge board_clk);
        check("hold_on", 32'(pixel_on), 32'd1);
        check("hold_id", 32'(pixel_id), 32'd1);
        render("p1_miss", 447, 251, 1'b1, 1'b0, 2'd0);

        // asynchronous reset mid-run
        start  = 1'b1;
        btn_dn = 2'b01;
        cycles(4);
        wait_ticks(2);
        check("run2_pos0", pos(0), 32'd244);
        render("moved_hit", 224, 240, 1'b1, 1'b1, 2'd0);
        #2 reset = 1'b1;
        #1;
        check("async_pos0", pos(0), 32'd240);
        check("async_state", 32'(state), 32'd0);
        check("async_pixel_on", 32'(pixel_on), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        cycles(2);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
